// File: rtl/loop_addr_gen_pkg.sv
// Shared defaults and FSM encoding for the strided loop address walker.
package loop_addr_gen_pkg;

  localparam int LOOP_ID_W_DEF = 5;
  localparam int ADDR_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/loop_addr_gen_regfile.sv
// Per-loop stride and saved-address storage: one write port each, shared async read index.
module loop_addr_gen_regfile
  import loop_addr_gen_pkg::*;
#(
  parameter int LOOP_ID_W = LOOP_ID_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_LOOPS = 1 << LOOP_ID_W
) (
  input  logic                 clk,
  input  logic                 stride_we,
  input  logic [LOOP_ID_W-1:0] stride_wid,
  input  logic [ADDR_W-1:0]    stride_wdata,
  input  logic                 saved_we,
  input  logic [LOOP_ID_W-1:0] saved_wid,
  input  logic [ADDR_W-1:0]    saved_wdata,
  input  logic [LOOP_ID_W-1:0] rd_id,
  output logic [ADDR_W-1:0]    stride_rdata,
  output logic [ADDR_W-1:0]    saved_rdata
);

  logic [ADDR_W-1:0] stride_mem [NUM_LOOPS];
  logic [ADDR_W-1:0] saved_mem  [NUM_LOOPS];

  // Storage only; contents are meaningful once written, so no reset.
  always_ff @(posedge clk) begin
    if (stride_we) stride_mem[stride_wid] <= stride_wdata;
  end

  always_ff @(posedge clk) begin
    if (saved_we) saved_mem[saved_wid] <= saved_wdata;
  end

  assign stride_rdata = stride_mem[rd_id];
  assign saved_rdata  = saved_mem[rd_id];

endmodule

// File: rtl/loop_addr_gen.sv
// Strided address walker: turns controller loop events into one address per innermost
// iteration on a valid/ready output, stalling the controller while the output is blocked.
module loop_addr_gen
  import loop_addr_gen_pkg::*;
#(
  parameter int LOOP_ID_W = LOOP_ID_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_LOOPS = 1 << LOOP_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LOOP_ID_W-1:0] cfg_inner_loop_id,
  input  logic                 cfg_addr_stride_v,
  input  logic [ADDR_W-1:0]    cfg_addr_stride,
  input  logic [LOOP_ID_W-1:0] cfg_addr_stride_loop_id,
  input  logic [LOOP_ID_W-1:0] loop_index,
  input  logic                 loop_index_valid,
  input  logic                 loop_last_iter,
  input  logic                 loop_enter,
  input  logic                 ctrl_done,
  output logic                 stall,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 addr_out_valid,
  input  logic                 addr_out_ready,
  output logic                 done
);

  state_t                   state;
  logic [ADDR_W-1:0]        cur_addr;
  logic [LOOP_ID_W-1:0]     inner_id;
  logic [ADDR_W-1:0]        stride_raw;
  logic signed [ADDR_W-1:0] stride_rd;
  logic [ADDR_W-1:0]        saved_rd;
  logic [ADDR_W-1:0]        rewind_addr;
  logic                     take;
  logic                     do_save;
  logic                     do_step;
  logic                     do_rewind;
  logic                     do_emit;

  // Modulo-2^ADDR_W add of a two's complement stride.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0]        a,
                                                 input logic signed [ADDR_W-1:0] s);
    return a + $unsigned(s);
  endfunction

  assign stall     = addr_out_valid & ~addr_out_ready;
  assign stride_rd = $signed(stride_raw);

  // An event is consumed once: only in WALK, only when not stalled, and never under start.
  assign take      = (state == ST_WALK) & ~stall & ~start;
  assign do_save   = take & loop_enter;
  assign do_step   = take & loop_index_valid & ~loop_last_iter;
  assign do_rewind = take & loop_index_valid & loop_last_iter;
  assign do_emit   = take & loop_index_valid & (loop_index == inner_id);

  // Enter and last-iteration together: the rewind target is the value being saved this cycle.
  assign rewind_addr = loop_enter ? cur_addr : saved_rd;

  loop_addr_gen_regfile #(
    .LOOP_ID_W (LOOP_ID_W),
    .ADDR_W    (ADDR_W),
    .NUM_LOOPS (NUM_LOOPS)
  ) u_regfile (
    .clk          (clk),
    .stride_we    (cfg_addr_stride_v),
    .stride_wid   (cfg_addr_stride_loop_id),
    .stride_wdata (cfg_addr_stride),
    .saved_we     (do_save),
    .saved_wid    (loop_index),
    .saved_wdata  (cur_addr),
    .rd_id        (loop_index),
    .stride_rdata (stride_raw),
    .saved_rdata  (saved_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cur_addr       <= '0;
      inner_id       <= '0;
      addr_out       <= '0;
      addr_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cur_addr       <= base_addr;
        inner_id       <= cfg_inner_loop_id;
        addr_out_valid <= 1'b0;
        state          <= ST_WALK;
      end else begin
        if (do_step) begin
          cur_addr <= wrap_add(cur_addr, stride_rd);
        end else if (do_rewind) begin
          cur_addr <= rewind_addr;
        end

        if (do_emit) begin
          addr_out       <= cur_addr;
          addr_out_valid <= 1'b1;
        end else if (addr_out_valid && addr_out_ready) begin
          addr_out_valid <= 1'b0;
        end

        // DRAIN waits for the last address to be taken before signalling completion.
        case (state)
          ST_IDLE: ;
          ST_WALK: begin
            if (ctrl_done) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (!addr_out_valid) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_addr_gen.sv
// Randomised and directed bench for loop_addr_gen with a closed-form nested-loop address model.
module tb_loop_addr_gen;

  localparam int LW = 5;
  localparam int AW = 32;

  typedef struct packed {
    logic [LW-1:0] idx;
    logic          vld;
    logic          last;
    logic          enter;
    logic          sw;
    logic [LW-1:0] sw_id;
    logic [AW-1:0] sw_val;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] cfg_inner_loop_id;
  logic          cfg_addr_stride_v;
  logic [AW-1:0] cfg_addr_stride;
  logic [LW-1:0] cfg_addr_stride_loop_id;
  logic [LW-1:0] loop_index;
  logic          loop_index_valid;
  logic          loop_last_iter;
  logic          loop_enter;
  logic          ctrl_done;
  logic          stall;
  logic [AW-1:0] addr_out;
  logic          addr_out_valid;
  logic          addr_out_ready;
  logic          done;

  loop_addr_gen #(.LOOP_ID_W(LW), .ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .base_addr               (base_addr),
    .cfg_inner_loop_id       (cfg_inner_loop_id),
    .cfg_addr_stride_v       (cfg_addr_stride_v),
    .cfg_addr_stride         (cfg_addr_stride),
    .cfg_addr_stride_loop_id (cfg_addr_stride_loop_id),
    .loop_index              (loop_index),
    .loop_index_valid        (loop_index_valid),
    .loop_last_iter          (loop_last_iter),
    .loop_enter              (loop_enter),
    .ctrl_done               (ctrl_done),
    .stall                   (stall),
    .addr_out                (addr_out),
    .addr_out_valid          (addr_out_valid),
    .addr_out_ready          (addr_out_ready),
    .done                    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int cyc = 0;
  int d0 = 0;
  int ncyc = 0;
  int done_cnt = 0;
  int done_at = 0;
  int acc_at = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  bit prev_start = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  ev_t           evq[$];
  logic [AW-1:0] newexp[$];
  logic [AW-1:0] expq[$];
  logic [AW-1:0] got[$];
  logic [AW-1:0] want[$];

  logic [LW-1:0] g_ids[3];
  int            g_cnt[3];
  logic [AW-1:0] g_str[3];

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, g, w);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk($sformatf("%s_len", tag), 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_addr%0d", tag, i), got[i], want[i]);
    end
  endtask

  // Reference: accepted addresses are compared in order against the expected queue.
  always @(negedge clk) begin
    ncyc++;
    checks++;
    if (stall !== (addr_out_valid & ~addr_out_ready)) begin
      errors++;
      $display("FAIL stall got=%b want=%b", stall, addr_out_valid & ~addr_out_ready);
    end
    if (stall === 1'b1) stall_cnt++;
    if (!reset && prev_stall && !prev_start) begin
      checks++;
      if (addr_out_valid !== 1'b1 || addr_out !== prev_addr) begin
        errors++;
        $display("FAIL hold got=0x%0h/v%b want=0x%0h/v1", addr_out, addr_out_valid, prev_addr);
      end
    end
    if (addr_out_valid === 1'b1 && addr_out_ready === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL extra_addr got=0x%0h want=none", addr_out);
      end else begin
        if (addr_out !== expq[0]) begin
          errors++;
          $display("FAIL addr got=0x%0h want=0x%0h", addr_out, expq[0]);
        end
        void'(expq.pop_front());
      end
      got.push_back(addr_out);
      acc_at = ncyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = ncyc;
      checks++;
      if (addr_out_valid !== 1'b0 || expq.size() != 0) begin
        errors++;
        $display("FAIL done_early got=valid%b/left%0d want=valid0/left0", addr_out_valid, expq.size());
      end
    end
    prev_stall = stall;
    prev_start = start;
    prev_addr  = addr_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      1:       addr_out_ready = ($urandom_range(0, 3) != 0);
      2:       addr_out_ready = !(cyc >= 3 && cyc <= 5);
      3:       addr_out_ready = (cyc >= d0 + 3);
      default: addr_out_ready = 1'b1;
    endcase
  endtask

  task automatic drive_idle();
    loop_index = '0; loop_index_valid = 1'b0; loop_last_iter = 1'b0; loop_enter = 1'b0;
    cfg_addr_stride_v = 1'b0; cfg_addr_stride_loop_id = '0; cfg_addr_stride = '0;
  endtask

  task automatic drive_ev(input ev_t e);
    loop_index = e.idx; loop_index_valid = e.vld; loop_last_iter = e.last; loop_enter = e.enter;
    cfg_addr_stride_v = e.sw; cfg_addr_stride_loop_id = e.sw_id; cfg_addr_stride = e.sw_val;
  endtask

  function automatic ev_t mk(input logic [LW-1:0] idx, input logic vld, input logic last,
                             input logic enter, input logic sw, input logic [AW-1:0] sw_val);
    ev_t e;
    e.idx = idx; e.vld = vld; e.last = last; e.enter = enter;
    e.sw = sw; e.sw_id = idx; e.sw_val = sw_val;
    return e;
  endfunction

  task automatic wstride(input logic [LW-1:0] id, input logic [AW-1:0] val);
    tick();
    cfg_addr_stride_v = 1'b1; cfg_addr_stride_loop_id = id; cfg_addr_stride = val;
    tick();
    cfg_addr_stride_v = 1'b0;
  endtask

  // Nested loops, innermost at level 0; address = base + sum(index_k * stride_k).
  task automatic build_nest(input int L, input logic [AW-1:0] base);
    evq.delete();
    newexp.delete();
    if (L >= 3) evq.push_back(mk(g_ids[2], 0, 0, 1, 0, '0));
    for (int i2 = 0; i2 < ((L >= 3) ? g_cnt[2] : 1); i2++) begin
      if (L >= 2) evq.push_back(mk(g_ids[1], 0, 0, 1, 0, '0));
      for (int i1 = 0; i1 < ((L >= 2) ? g_cnt[1] : 1); i1++) begin
        for (int i0 = 0; i0 < g_cnt[0]; i0++) begin
          evq.push_back(mk(g_ids[0], 1, i0 == g_cnt[0] - 1, i0 == 0, 0, '0));
          newexp.push_back(base + g_str[0] * 32'(i0) + g_str[1] * 32'(i1) + g_str[2] * 32'(i2));
        end
        if (L >= 2) evq.push_back(mk(g_ids[1], 1, i1 == g_cnt[1] - 1, 0, 0, '0));
      end
      if (L >= 3) evq.push_back(mk(g_ids[2], 1, i2 == g_cnt[2] - 1, 0, 0, '0));
    end
  endtask

  task automatic run_walk(input logic [AW-1:0] base, input logic [LW-1:0] inner,
                          input int abort_after, input bit bubbles, input bit drain,
                          input bit done_last);
    int  n;
    int  dc0;
    bit  first;
    dc0 = done_cnt;
    tick();
    drive_idle();
    ctrl_done = 1'b0;
    start = 1'b1; base_addr = base; cfg_inner_loop_id = inner;
    cyc = -1;
    first = 1'b1;
    for (int k = 0; k < evq.size(); k++) begin
      if (abort_after > 0 && k == abort_after) return;
      if (!first && bubbles && $urandom_range(0, 3) == 0) begin
        tick();
        drive_idle();
      end
      tick();
      if (first) begin
        start = 1'b0;
        expq = newexp;
        got.delete();
        first = 1'b0;
      end
      drive_ev(evq[k]);
      if (done_last && k == evq.size() - 1) ctrl_done = 1'b1;
      n = 0;
      @(negedge clk);
      while (stall && n < 200) begin
        tick();
        @(negedge clk);
        n++;
      end
      if (stall) begin
        chk("stall_timeout", 32'(n), 32'd0);
        return;
      end
    end
    tick();
    drive_idle();
    if (done_last) begin
      ctrl_done = 1'b0;
    end else begin
      ctrl_done = 1'b1;
      if (drain) begin
        addr_out_ready = 1'b0;
        d0 = cyc;
        ready_mode = 3;
      end
      tick();
      ctrl_done = 1'b0;
    end
    n = 0;
    while (done_cnt == dc0 && n < 60) begin
      tick();
      n++;
    end
    if (done_cnt == dc0) chk("done_timeout", 32'(done_cnt - dc0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic finish_walk(input string tag);
    chk($sformatf("%s_left", tag), 32'(expq.size()), 32'd0);
    chk($sformatf("%s_done", tag), 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; cfg_inner_loop_id = '0; ctrl_done = 1'b0;
    addr_out_ready = 1'b1;
    drive_idle();
    #2;
    chk("rst_valid", 32'(addr_out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", addr_out, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Nested 2x3 walk.
    g_ids[0] = 5'd0; g_ids[1] = 5'd1; g_ids[2] = 5'd2;
    g_cnt[0] = 3; g_cnt[1] = 2; g_cnt[2] = 1;
    g_str[0] = 32'h4; g_str[1] = 32'h100; g_str[2] = 32'h0;
    wstride(0, 32'h4);
    wstride(1, 32'h100);
    build_nest(2, 32'h1000);
    want = '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1104, 32'h1108};
    for (int i = 0; i < 6; i++) chk($sformatf("model%0d", i), newexp[i], want[i]);
    ready_mode = 0; done_cnt = 0;
    run_walk(32'h1000, 5'd0, 0, 0, 0, 0);
    finish_walk("nest");
    chk_seq("nest");

    // Backpressure window of three cycles.
    ready_mode = 2; done_cnt = 0; stall_cnt = 0;
    build_nest(2, 32'h1000);
    run_walk(32'h1000, 5'd0, 0, 0, 0, 0);
    finish_walk("bp");
    chk("bp_stalls", 32'(stall_cnt), 32'd3);
    chk_seq("bp");

    // Negative stride wraps through zero.
    ready_mode = 0; done_cnt = 0;
    wstride(0, 32'hFFFF_FFFC);
    g_cnt[0] = 3; g_str[0] = 32'hFFFF_FFFC;
    build_nest(1, 32'h0);
    run_walk(32'h0, 5'd0, 0, 0, 0, 0);
    finish_walk("wrap");
    want = '{32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    chk_seq("wrap");

    // Enter with first iteration saves the pre-increment address.
    done_cnt = 0;
    wstride(0, 32'h8);
    evq = '{mk(0, 1, 0, 1, 0, '0), mk(0, 1, 1, 0, 0, '0), mk(0, 1, 0, 0, 0, '0), mk(0, 1, 1, 0, 0, '0)};
    newexp = '{32'h100, 32'h108, 32'h100, 32'h108};
    run_walk(32'h100, 5'd0, 0, 0, 0, 0);
    finish_walk("save");
    want = newexp;
    chk_seq("save");

    // Stride write in the same cycle as its use: the old stride applies first.
    done_cnt = 0;
    wstride(0, 32'h4);
    evq = '{mk(0, 1, 0, 1, 1, 32'h10), mk(0, 1, 0, 0, 0, '0), mk(0, 1, 1, 0, 0, '0)};
    newexp = '{32'h200, 32'h204, 32'h214};
    run_walk(32'h200, 5'd0, 0, 0, 0, 0);
    finish_walk("swr");
    want = newexp;
    chk_seq("swr");

    // Abort by a new start mid-walk.
    done_cnt = 0;
    wstride(0, 32'h4);
    g_cnt[0] = 3; g_cnt[1] = 2; g_str[0] = 32'h4; g_str[1] = 32'h100;
    build_nest(2, 32'h1000);
    run_walk(32'h1000, 5'd0, 5, 0, 0, 0);
    build_nest(2, 32'h2000);
    run_walk(32'h2000, 5'd0, 0, 0, 0, 0);
    finish_walk("abort");
    if (got.size() > 0) chk("abort_first", got[0], 32'h2000);
    else chk("abort_first", 32'hDEAD_BEEF, 32'h2000);

    // Asynchronous reset mid-walk, then loop events in IDLE must do nothing.
    done_cnt = 0;
    build_nest(2, 32'h1000);
    run_walk(32'h1000, 5'd0, 4, 0, 0, 0);
    tick();
    drive_idle();
    #2 reset = 1'b1;
    expq.delete();
    #1;
    chk("rst_mid_valid", 32'(addr_out_valid), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_addr", addr_out, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_ev(mk(0, 1, 0, 1, 0, '0));
      ctrl_done = 1'b1;
      @(negedge clk);
    end
    tick();
    drive_idle();
    ctrl_done = 1'b0;
    repeat (3) tick();
    chk("idle_valid", 32'(addr_out_valid), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd0);

    // Drain: ctrl_done while an address is held by ready=0.
    done_cnt = 0;
    ready_mode = 0;
    wstride(7, 32'h40);
    g_ids[0] = 5'd7; g_cnt[0] = 2; g_str[0] = 32'h40; g_str[1] = '0; g_str[2] = '0;
    build_nest(1, 32'h300);
    run_walk(32'h300, 5'd7, 0, 0, 1, 0);
    finish_walk("drain");
    chk("drain_gap", 32'(done_at - acc_at), 32'd2);
    want = '{32'h300, 32'h340};
    chk_seq("drain");

    // ctrl_done together with the final emitting event.
    ready_mode = 0; done_cnt = 0;
    g_cnt[0] = 3;
    build_nest(1, 32'h500);
    run_walk(32'h500, 5'd7, 0, 0, 0, 1);
    finish_walk("dlast");
    want = '{32'h500, 32'h540, 32'h580};
    chk_seq("dlast");

    // Random nests, strides, bases, ids, bubbles and backpressure.
    for (int w = 0; w < 8; w++) begin
      int            lv;
      logic [AW-1:0] base;
      lv = $urandom_range(1, 3);
      g_ids[0] = 5'($urandom_range(0, 31));
      g_ids[1] = g_ids[0] + 5'($urandom_range(1, 15));
      g_ids[2] = g_ids[1] + 5'($urandom_range(1, 15));
      for (int k = 0; k < 3; k++) begin
        g_cnt[k] = $urandom_range(1, 4);
        g_str[k] = $urandom();
        if (k < lv) wstride(g_ids[k], g_str[k]);
      end
      base = $urandom();
      ready_mode = 1; done_cnt = 0;
      build_nest(lv, base);
      run_walk(base, g_ids[0], 0, 1, 0, 0);
      finish_walk($sformatf("rand%0d", w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
